// File: rtl/sr_flipflop.sv
// Clocked SR storage element, WIDTH independent cells.
// Every cell updates on the rising clock edge from its own S/R bit pair.
// The response to S=R=1 is fixed at elaboration by BOTH_POLICY.
// q comes straight from the flops, so there is no combinational path to it.
module sr_flipflop #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               BOTH_POLICY = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] q
);

    // Action taken by a cell when set and clear are requested together.
    typedef enum logic [1:0] {
        BOTH_HOLD   = 2'd0,
        BOTH_SET    = 2'd1,
        BOTH_CLR    = 2'd2,
        BOTH_TOGGLE = 2'd3
    } both_e;

    // Out-of-range policy values fall back to hold.
    localparam both_e POLICY = (BOTH_POLICY == 1) ? BOTH_SET    :
                               (BOTH_POLICY == 2) ? BOTH_CLR    :
                               (BOTH_POLICY == 3) ? BOTH_TOGGLE :
                                                    BOTH_HOLD;

    // Next state of a single cell from its set/clear request and current value.
    function automatic logic next_bit(input logic s, input logic r, input logic cur);
        logic nxt;
        nxt = cur;
        case ({s, r})
            2'b10:   nxt = 1'b1;
            2'b01:   nxt = 1'b0;
            2'b11: begin
                case (POLICY)
                    BOTH_SET:    nxt = 1'b1;
                    BOTH_CLR:    nxt = 1'b0;
                    BOTH_TOGGLE: nxt = ~cur;
                    default:     nxt = cur;
                endcase
            end
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    // State register: reset has priority over every S/R combination.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                q[i] <= next_bit(S[i], R[i], q[i]);
            end
        end
    end

endmodule

// File: tb/tb_sr_flipflop.sv
// Self-checking bench for sr_flipflop: five 1-bit cells covering every
// simultaneous-request policy (including an out-of-range value) plus a 4-bit
// toggle-policy vector with a non-zero reset value, compared each edge
// against a bitwise reference model.
module tb_sr_flipflop;

    logic       clk;
    logic       reset;
    logic       s1, r1;
    logic [3:0] s4, r4;
    logic       q_p0, q_p1, q_p2, q_p3, q_p5;
    logic [3:0] q_v;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: index 0..4 are the 1-bit cells, mqv the vector.
    int         pols [5] = '{0, 1, 2, 3, 5};
    logic [3:0] mq   [5];
    logic [3:0] mqv;

    sr_flipflop #(.WIDTH(1), .RESET_VALUE(1'b0), .BOTH_POLICY(0)) u_p0 (
        .clk(clk), .reset(reset), .S(s1), .R(r1), .q(q_p0));
    sr_flipflop #(.WIDTH(1), .RESET_VALUE(1'b0), .BOTH_POLICY(1)) u_p1 (
        .clk(clk), .reset(reset), .S(s1), .R(r1), .q(q_p1));
    sr_flipflop #(.WIDTH(1), .RESET_VALUE(1'b0), .BOTH_POLICY(2)) u_p2 (
        .clk(clk), .reset(reset), .S(s1), .R(r1), .q(q_p2));
    sr_flipflop #(.WIDTH(1), .RESET_VALUE(1'b0), .BOTH_POLICY(3)) u_p3 (
        .clk(clk), .reset(reset), .S(s1), .R(r1), .q(q_p3));
    sr_flipflop #(.WIDTH(1), .RESET_VALUE(1'b0), .BOTH_POLICY(5)) u_p5 (
        .clk(clk), .reset(reset), .S(s1), .R(r1), .q(q_p5));
    sr_flipflop #(.WIDTH(4), .RESET_VALUE(4'b1010), .BOTH_POLICY(3)) u_vec (
        .clk(clk), .reset(reset), .S(s4), .R(r4), .q(q_v));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Bitwise reference: partition bits into idle / set-only / clear-only / both.
    function automatic logic [3:0] model_next(input int pol, input logic [3:0] cur,
                                              input logic [3:0] s, input logic [3:0] r);
        logic [3:0] idle, only_s, both, both_res;
        idle   = ~s & ~r;
        only_s = s & ~r;
        both   = s & r;
        if (pol == 1)      both_res = both;
        else if (pol == 2) both_res = 4'b0000;
        else if (pol == 3) both_res = ~cur & both;
        else               both_res = cur & both;
        return (cur & idle) | only_s | both_res;
    endfunction

    // Drive inputs, take one rising edge, advance the model, compare all outputs.
    task automatic tick(input logic rst_v, input logic s1_v, input logic r1_v,
                        input logic [3:0] s4_v, input logic [3:0] r4_v);
        reset = rst_v;
        s1    = s1_v;
        r1    = r1_v;
        s4    = s4_v;
        r4    = r4_v;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            mq[i] = rst_v ? 4'b0000 : model_next(pols[i], mq[i], {3'b000, s1_v}, {3'b000, r1_v});
        end
        mqv = rst_v ? 4'b1010 : model_next(3, mqv, s4_v, r4_v);
        #1;
        check("p0",  {3'b000, q_p0}, mq[0]);
        check("p1",  {3'b000, q_p1}, mq[1]);
        check("p2",  {3'b000, q_p2}, mq[2]);
        check("p3",  {3'b000, q_p3}, mq[3]);
        check("p5",  {3'b000, q_p5}, mq[4]);
        check("vec", q_v, mqv);
    endtask

    logic [1:0] seq   [6] = '{2'b10, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01};
    logic       exp_b [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       exp_t [3] = '{1'b1, 1'b0, 1'b1};

    initial begin
        reset = 1'b1; s1 = 1'b0; r1 = 1'b0; s4 = 4'h0; r4 = 4'h0;
        for (int i = 0; i < 5; i++) mq[i] = 4'b0000;
        mqv = 4'b1010;
        #2;

        // Reset with idle inputs, then reset overriding a set request.
        tick(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        tick(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        check("rst_idle", {3'b000, q_p0}, 4'b0000);
        check("rst_vec",  q_v, 4'b1010);
        tick(1'b1, 1'b1, 1'b0, 4'hF, 4'h0);
        check("rst_over_set", {3'b000, q_p0}, 4'b0000);
        check("rst_over_vec", q_v, 4'b1010);

        // Basic hold-policy sequence.
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, seq[i][1], seq[i][0], 4'h0, 4'h0);
            check("basic", {3'b000, q_p0}, {3'b000, exp_b[i]});
        end

        // Set then hold, then both requests under hold policy.
        tick(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
            check("hold_set", {3'b000, q_p0}, 4'b0001);
        end
        tick(1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
        check("hold_both", {3'b000, q_p0}, 4'b0001);

        // Policy variants from q=0 with both requests held.
        tick(1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
            check("pol_set",    {3'b000, q_p1}, 4'b0001);
            check("pol_clr",    {3'b000, q_p2}, 4'b0000);
            check("pol_toggle", {3'b000, q_p3}, {3'b000, exp_t[i]});
            check("pol_bad",    {3'b000, q_p5}, 4'b0000);
        end

        // Reset in the middle of operation, then first edge after release.
        tick(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        check("pre_mid", {3'b000, q_p0}, 4'b0001);
        tick(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
        check("mid_rst", {3'b000, q_p0}, 4'b0000);
        tick(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        check("post_rst", {3'b000, q_p0}, 4'b0001);

        // Vector: mixed per-bit commands from the reset value.
        tick(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        tick(1'b0, 1'b0, 1'b0, 4'b0101, 4'b1000);
        check("vec_mixed", q_v, 4'b0111);
        tick(1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111);
        check("vec_toggle", q_v, 4'b1000);

        // Randomized traffic with mid-cycle input wiggling that must be ignored.
        for (int n = 0; n < 400; n++) begin
            s1 = 1'($urandom); r1 = 1'($urandom);
            s4 = 4'($urandom); r4 = 4'($urandom);
            #2;
            tick(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom),
                 4'($urandom), 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_flipflop.md
Name: sr_flipflop

Overview:
Clocked SR (set/reset) storage element with a synchronous, active-high reset. It is a general-purpose state bit (or vector of independent bits) used in control logic wherever separate set and clear requests latch a flag. All state changes occur on the rising clock edge. The response to simultaneous S and R is defined deterministically by a parameter, so the simultaneous case is never undefined.

Parameters:
WIDTH, 1, number of independent SR cells; S, R and q are WIDTH bits wide, and bit i of q is controlled only by bit i of S and R.
RESET_VALUE, '0 (all zeros), value loaded into q on reset; WIDTH bits.
BOTH_POLICY, 0, action per bit when S=1 and R=1 together: 0 = hold, 1 = set dominant, 2 = reset dominant, 3 = toggle. Any other value behaves as 0.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
S  input  WIDTH  set request, per bit.
R  input  WIDTH  reset (clear) request, per bit.
q  output  WIDTH  registered state, driven directly from the flop with no combinational path from the inputs.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset:
  - When reset=1 at a rising edge of clk, q becomes RESET_VALUE, regardless of S and R.
  - Reset has priority over every S/R combination.
  - Before the first rising edge, q is not required to hold a defined value.
- Per-bit update when reset=0, evaluated at each rising edge using the S and R values sampled at that edge:
  - S=0, R=0: hold; q keeps its previous value.
  - S=1, R=0: q becomes 1.
  - S=0, R=1: q becomes 0.
  - S=1, R=1: follows BOTH_POLICY. Hold keeps q; set dominant gives 1; reset dominant gives 0; toggle gives the inverse of the previous q.
- Latency: q reflects the inputs one edge after they are sampled. There is no asynchronous or combinational path to q.
- Bits are fully independent; mixed commands in one cycle are each applied to their own bit.
- Reset asserted mid-sequence clears q on the next edge. The first edge after reset deasserts applies the S/R values present at that edge.
- Inputs that change between edges have no effect on q.
- Holding S/R constant at 1/0 for many cycles keeps q=1 and produces no glitches. Toggle policy with S=R=1 held flips q every cycle.

Test Plan:
- Reset: reset=1, S=0, R=0 for 2 edges -> q=0 (RESET_VALUE); then reset=1 with S=1, R=0 -> q stays 0.
- Basic sequence (WIDTH=1, BOTH_POLICY=0): release reset, then apply one edge each of S/R = 10, 01, 00, 11, 10, 01 -> q after each edge = 1, 0, 0, 0, 1, 0.
- Hold after set: S/R=10 for 1 edge, then 00 for 3 edges -> q=1 throughout; then 11 for 1 edge -> q stays 1.
- Policy variants with S=R=1 starting from q=0: policy 1 -> q=1; policy 2 -> q=0; policy 3 -> q alternates 1, 0, 1 over three edges.
- Reset mid-operation: q=1, assert reset for one edge with S=1 -> q=0; deassert with S/R=10 -> q=1 on the next edge.
- Vector (WIDTH=4, RESET_VALUE=4'b1010): after reset q=1010; S=0101, R=1000 -> q=0111.
